// File: rtl/store_buffer.sv
// Posted-write store buffer: a DEPTH-entry FIFO drained to a valid/ready data bus,
// with youngest-match store-to-load forwarding so loads observe program order.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   MemWriteW,
    input  logic [AW-1:0]          ALUResultW,
    input  logic [DW-1:0]          WriteData,
    input  logic [DW-1:0]          MemReadData,
    output logic [DW-1:0]          ReadData,
    output logic                   StallMem,
    output logic                   BufEmpty,
    output logic [$clog2(DEPTH):0] BufCount,
    output logic                   BusValid,
    output logic [AW-1:0]          BusAddr,
    output logic [DW-1:0]          BusWData,
    input  logic                   BusReady
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW:0]      count_q, count_d;
    logic [PW:0]      remain;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]    bus_addr_q, bus_addr_d;
    logic [DW-1:0]    bus_wdata_q, bus_wdata_d;
    logic [AW-1:0]    addr_mem_q [DEPTH];
    logic [DW-1:0]    data_mem_q [DEPTH];
    logic [PW-1:0]    fwd_idx;
    logic             full;
    logic             drain_fire;
    logic             accept;

    always_comb begin
        full       = (count_q == (PW+1)'(DEPTH));
        BusValid   = (count_q != '0);
        drain_fire = BusValid & BusReady;
        accept     = MemWriteW & (~full | drain_fire);
        StallMem   = MemWriteW & full & ~drain_fire;
        BufEmpty   = (count_q == '0);
        BufCount   = count_q;
        BusAddr    = bus_addr_q;
        BusWData   = bus_wdata_q;
    end

    always_comb begin
        head_d  = drain_fire ? head_q + PW'(1) : head_q;
        tail_d  = accept ? tail_q + PW'(1) : tail_q;
        count_d = count_q + {{PW{1'b0}}, accept} - {{PW{1'b0}}, drain_fire};
        remain  = count_q - {{PW{1'b0}}, drain_fire};
        valid_d = valid_q;
        if (drain_fire) valid_d[head_q] = 1'b0;
        // When full, tail == head: the drained slot is refilled in the same cycle.
        if (accept) valid_d[tail_q] = 1'b1;
        // Bus outputs are registered copies of the next head; they hold once empty.
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if (count_d != '0) begin
            if (remain == '0) begin
                bus_addr_d  = ALUResultW;
                bus_wdata_d = WriteData;
            end else begin
                bus_addr_d  = addr_mem_q[head_d];
                bus_wdata_d = data_mem_q[head_d];
            end
        end
    end

    // Walk oldest to youngest from head so the last hit is the youngest store.
    always_comb begin
        ReadData = MemReadData;
        fwd_idx  = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if (valid_q[fwd_idx] && (addr_mem_q[fwd_idx][AW-1:2] == ALUResultW[AW-1:2]))
                ReadData = data_mem_q[fwd_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_mem_q[tail_q] <= ALUResultW;
            data_mem_q[tail_q] <= WriteData;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: scoreboard of accepted stores checked against bus drains,
// plus directed checks of stalling, forwarding, pointer wrap and async reset.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWriteW = 1'b0;
    logic [31:0] ALUResultW = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] MemReadData = 32'hCAFE_F00D;
    logic [31:0] ReadData;
    logic        StallMem;
    logic        BufEmpty;
    logic [2:0]  BufCount;
    logic        BusValid;
    logic [31:0] BusAddr;
    logic [31:0] BusWData;
    logic        BusReady = 1'b0;

    int          total = 0;
    int          bad = 0;
    logic [63:0] sb[$];
    logic [63:0] mon_exp;

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset), .MemWriteW(MemWriteW), .ALUResultW(ALUResultW),
        .WriteData(WriteData), .MemReadData(MemReadData), .ReadData(ReadData),
        .StallMem(StallMem), .BufEmpty(BufEmpty), .BufCount(BufCount),
        .BusValid(BusValid), .BusAddr(BusAddr), .BusWData(BusWData), .BusReady(BusReady)
    );

    always #5 clk = ~clk;

    // Bus monitor: every drain must match the oldest expected store.
    always @(negedge clk) begin
        if (reset && BusValid && BusReady) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL bus_unexpected: got addr=%h data=%h, required no drain", BusAddr, BusWData);
            end else begin
                mon_exp = sb.pop_front();
                if ({BusAddr, BusWData} !== mon_exp) begin
                    bad++;
                    $display("FAIL bus_order: got %h/%h, required %h/%h",
                             BusAddr, BusWData, mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        logic done;
        logic exp_stall;
        done = 1'b0;
        MemWriteW  = 1'b1;
        ALUResultW = a;
        WriteData  = d;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            exp_stall = (sb.size() == DEPTH) && !BusReady;
            total++;
            if (StallMem !== exp_stall) begin
                bad++;
                $display("FAIL stall_%h: got %b, required %b", a, StallMem, exp_stall);
            end
            @(posedge clk);
            if (!exp_stall) begin
                sb.push_back({a, d});
                done = 1'b1;
            end
            #1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL store_timeout: got no accept, required accept of %h", a);
        end
    endtask

    task automatic wait_empty(input logic toggle);
        for (int k = 0; k < 40 && BufEmpty !== 1'b1; k++) begin
            if (toggle) BusReady = ~BusReady;
            tick();
        end
        total++;
        if (BufEmpty !== 1'b1) begin
            bad++;
            $display("FAIL drain_timeout: got BufEmpty=%b, required 1", BufEmpty);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_missing: got %0d undrained, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({BusValid, BusAddr, BusWData, BufEmpty, BufCount, StallMem} !== {1'b0, 32'h0, 32'h0, 1'b1, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got v=%b a=%h d=%h e=%b c=%0d s=%b, required 0/0/0/1/0/0",
                     BusValid, BusAddr, BusWData, BufEmpty, BufCount, StallMem);
        end
        total++;
        if (ReadData !== MemReadData) begin
            bad++;
            $display("FAIL reset_read: got %h, required %h", ReadData, MemReadData);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        BusReady = 1'b1;
        total++;
        if (BusValid !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle_valid: got %b, required 0", BusValid);
        end
        do_store(32'h100, 32'h11);
        total++;
        if ({BusValid, BusAddr, BusWData} !== {1'b1, 32'h100, 32'h11}) begin
            bad++;
            $display("FAIL basic_first: got %b/%h/%h, required 1/100/11", BusValid, BusAddr, BusWData);
        end
        do_store(32'h104, 32'h22);
        total++;
        if ({BusValid, BusAddr, BusWData, BufEmpty} !== {1'b1, 32'h104, 32'h22, 1'b0}) begin
            bad++;
            $display("FAIL basic_second: got %b/%h/%h e=%b, required 1/104/22 e=0",
                     BusValid, BusAddr, BusWData, BufEmpty);
        end
        MemWriteW = 1'b0;
        tick();
        total++;
        if (BufEmpty !== 1'b1 || BusAddr !== 32'h104) begin
            bad++;
            $display("FAIL basic_empty: got e=%b a=%h, required e=1 a=104", BufEmpty, BusAddr);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL basic_drained: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_full();
        BusReady = 1'b0;
        for (int i = 0; i < 4; i++) do_store(32'h200 + 32'(4 * i), 32'h1000 + 32'(i));
        ALUResultW = 32'h210;
        WriteData  = 32'h1004;
        #1;
        total++;
        if (StallMem !== 1'b1 || BufCount !== 3'd4) begin
            bad++;
            $display("FAIL full_stall: got s=%b c=%0d, required s=1 c=4", StallMem, BufCount);
        end
        tick();
        #1;
        total++;
        if (StallMem !== 1'b1) begin
            bad++;
            $display("FAIL full_stall_hold: got %b, required 1", StallMem);
        end
        BusReady = 1'b1;
        #1;
        total++;
        if (StallMem !== 1'b0) begin
            bad++;
            $display("FAIL full_release: got %b, required 0", StallMem);
        end
        @(posedge clk);
        sb.push_back({32'h210, 32'h1004});
        #1;
        MemWriteW = 1'b0;
        total++;
        if (BufCount !== 3'd4) begin
            bad++;
            $display("FAIL full_no_bubble: got count=%0d, required 4", BufCount);
        end
        wait_empty(1'b0);
    endtask

    task automatic test_forward();
        BusReady = 1'b0;
        do_store(32'h300, 32'hAA);
        do_store(32'h300, 32'hBB);
        MemWriteW  = 1'b0;
        ALUResultW = 32'h302;
        #1;
        total++;
        if (ReadData !== 32'hBB) begin
            bad++;
            $display("FAIL fwd_youngest: got %h, required bb", ReadData);
        end
        ALUResultW = 32'h304;
        #1;
        total++;
        if (ReadData !== MemReadData) begin
            bad++;
            $display("FAIL fwd_miss: got %h, required %h", ReadData, MemReadData);
        end
        tick();
        MemWriteW  = 1'b1;
        ALUResultW = 32'h308;
        WriteData  = 32'hCC;
        #1;
        total++;
        if (ReadData !== MemReadData) begin
            bad++;
            $display("FAIL fwd_same_cycle: got %h, required %h", ReadData, MemReadData);
        end
        @(posedge clk);
        sb.push_back({32'h308, 32'hCC});
        #1;
        MemWriteW = 1'b0;
        #1;
        total++;
        if (ReadData !== 32'hCC) begin
            bad++;
            $display("FAIL fwd_next_cycle: got %h, required cc", ReadData);
        end
        BusReady = 1'b1;
        wait_empty(1'b0);
        ALUResultW = 32'h300;
        #1;
        total++;
        if (ReadData !== MemReadData) begin
            bad++;
            $display("FAIL fwd_after_drain: got %h, required %h", ReadData, MemReadData);
        end
        tick();
    endtask

    task automatic test_wrap();
        BusReady = 1'b0;
        do_store(32'h408, 32'h1);
        do_store(32'h40C, 32'h2);
        do_store(32'h410, 32'h3);
        do_store(32'h400, 32'hA1);
        MemWriteW = 1'b0;
        BusReady  = 1'b1;
        tick();
        tick();
        tick();
        BusReady = 1'b0;
        total++;
        if (BufCount !== 3'd1 || BusAddr !== 32'h400) begin
            bad++;
            $display("FAIL wrap_partial: got c=%0d a=%h, required c=1 a=400", BufCount, BusAddr);
        end
        do_store(32'h414, 32'hB1);
        do_store(32'h418, 32'hB2);
        do_store(32'h400, 32'hB3);
        MemWriteW  = 1'b0;
        ALUResultW = 32'h400;
        #1;
        total++;
        if (ReadData !== 32'hB3 || BufCount !== 3'd4) begin
            bad++;
            $display("FAIL wrap_fwd: got %h c=%0d, required b3 c=4", ReadData, BufCount);
        end
        BusReady = 1'b1;
        #1;
        total++;
        if (ReadData !== 32'hB3) begin
            bad++;
            $display("FAIL wrap_fwd_drain: got %h, required b3", ReadData);
        end
        tick();
        wait_empty(1'b1);
    endtask

    task automatic test_hold_reset();
        BusReady = 1'b0;
        do_store(32'h500, 32'h61);
        do_store(32'h504, 32'h62);
        MemWriteW = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if ({BusValid, BusAddr, BusWData} !== {1'b1, 32'h500, 32'h61}) begin
                bad++;
                $display("FAIL hold_%0d: got %b/%h/%h, required 1/500/61", k, BusValid, BusAddr, BusWData);
            end
        end
        ALUResultW = 32'h500;
        BusReady   = 1'b1;
        #1;
        total++;
        if (ReadData !== 32'h61) begin
            bad++;
            $display("FAIL head_fwd_drain: got %h, required 61", ReadData);
        end
        tick();
        BusReady = 1'b0;
        do_store(32'h508, 32'h63);
        do_store(32'h50C, 32'h64);
        MemWriteW = 1'b0;
        #1;
        total++;
        if (BufCount !== 3'd3) begin
            bad++;
            $display("FAIL pre_reset_count: got %0d, required 3", BufCount);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({BusValid, BufCount, BufEmpty, BusAddr, BusWData} !== {1'b0, 3'd0, 1'b1, 32'h0, 32'h0}) begin
            bad++;
            $display("FAIL async_reset: got v=%b c=%0d e=%b a=%h d=%h, required 0/0/1/0/0",
                     BusValid, BufCount, BufEmpty, BusAddr, BusWData);
        end
        sb.delete();
        tick();
        tick();
        reset    = 1'b1;
        BusReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (BusValid !== 1'b0) begin
                bad++;
                $display("FAIL stale_after_reset_%0d: got %b, required 0", k, BusValid);
            end
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_basic();
        test_full();
        test_forward();
        test_wrap();
        test_hold_reset();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL final_scoreboard: got %0d pending, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer that sits directly downstream of the core's writeback-stage memory outputs.
- Accepts store requests (MemWriteW, ALUResultW as byte address, WriteData) into a DEPTH-entry FIFO and drains them to the data bus with a valid/ready handshake.
- Returns ReadData to the core, forwarding the youngest matching buffered store ahead of bus memory so loads always see program-order data.

Parameters:
DEPTH, 4, number of buffered stores; power of two, at least 2
AW, 32, address width
DW, 32, data width (full-word stores only)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
MemWriteW  input  1  store request from core
ALUResultW  input  AW  store/load byte address
WriteData  input  DW  store data
MemReadData  input  DW  combinational read data from data memory at ALUResultW
ReadData  output  DW  load data returned to core
StallMem  output  1  store cannot be accepted this cycle
BufEmpty  output  1  no stores pending (fence/idle indication)
BufCount  output  $clog2(DEPTH)+1  number of valid entries
BusValid  output  1  head store presented to bus
BusAddr  output  AW  head store address
BusWData  output  DW  head store data
BusReady  input  1  bus accepts head store

Behaviour:
- Reset (reset=0, asynchronous): head/tail pointers=0, count=0, all entry valid bits cleared. Outputs: BusValid=0, BusAddr=0, BusWData=0, BufEmpty=1, BufCount=0, StallMem=0. Stores pending at reset assertion are discarded; BusValid drops immediately, without waiting for a clock edge.
- Storage: circular FIFO of {addr[AW-1:2], data}. addr[1:0] is stored but ignored for matching. Pointers wrap modulo DEPTH. full = (count==DEPTH).
- Drain: drain_fire = BusValid & BusReady.
  - BusValid = (count!=0). BusAddr/BusWData are driven from the head entry.
  - While BusValid=1 and BusReady=0, BusAddr and BusWData hold stable.
  - On drain_fire: head advances and the entry is invalidated at the clock edge.
  - When empty, BusAddr and BusWData hold their last values; they do not return to 0.
- Accept: accept = MemWriteW & (~full | drain_fire).
  - On accept: write the entry at tail; tail advances at the clock edge.
  - count_next = count + accept - drain_fire.
  - Full with a simultaneous drain is accepted, so no bubble occurs.
- StallMem = MemWriteW & full & ~drain_fire, combinational. While StallMem=1, upstream holds MemWriteW, ALUResultW and WriteData stable.
- Latency: a store accepted at edge N is presented with BusValid=1 in the cycle after edge N. Minimum latency from MemWriteW high to BusValid high is 1 cycle. Throughput is 1 store/cycle when BusReady is held high.
- Forwarding (combinational):
  - ReadData = data of the youngest valid entry whose addr[AW-1:2] equals ALUResultW[AW-1:2]. Otherwise ReadData = MemReadData.
  - Youngest is determined by age relative to head, with correct handling across pointer wrap.
  - The head entry is still forwardable in the cycle its drain_fire occurs.
  - A store being accepted in the current cycle is not forwarded until the next cycle.
- Ordering: stores leave in strict FIFO order. The bus sees every accepted store exactly once.
- BufEmpty = (count==0). BufCount reflects the registered count.

Test Plan:
- Reset release, BusReady=1, stores A=0x100/0x11, B=0x104/0x22 on consecutive cycles -> BusValid high one cycle after each; bus sees 0x100/0x11 then 0x104/0x22; BufEmpty returns to 1 two cycles after the last store.
- BusReady=0, five stores 0x200..0x210 (DEPTH=4) -> BufCount reaches 4; StallMem=1 on the fifth store. Raise BusReady -> the fifth store is accepted in the same cycle as the first drain; bus order is 0x200,0x204,0x208,0x20C,0x210.
- BusReady=0, store 0x300/0xAA then 0x300/0xBB, read ALUResultW=0x302 -> ReadData=0xBB (youngest, low bits ignored). Read 0x304 -> ReadData=MemReadData.
- Pointer wrap: fill, drain 3, refill 3 with BusReady toggling; duplicate address 0x400 is both the oldest and the newest entry -> forwarding returns the newest entry's data; bus sequence is complete and in order.
- BusReady=0 with BusValid held for 5 cycles -> BusAddr and BusWData remain stable. Assert reset mid-run with 3 entries pending -> BusValid=0 and BufCount=0 immediately; after release no stale store appears on the bus.
